// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants for the full adder family
package full_adder_pkg;
    localparam logic RST_VAL = 1'b0;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder with generate/propagate and optional output register
module full_adder
    import full_adder_pkg::*;
#(
    parameter int OUT_REG = 0
) (
    input  logic clk,
    input  logic rst,
    output logic s,
    output logic co,
    output logic g,
    output logic p,
    output logic out_valid,
    input  logic a,
    input  logic b,
    input  logic ci,
    input  logic in_valid
);
    logic [4:0] res_d;
    logic [4:0] res_q;
    logic [4:0] res;
    // result vector {out_valid, p, g, co, s}; carry built from generate/propagate
    always_comb begin
        res_d = {in_valid, a ^ b, a & b, (a & b) | ((a ^ b) & ci), a ^ b ^ ci};
        res   = (OUT_REG != 0) ? res_q : res_d;
    end
    // output register; async reset discards any in-flight result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= {5{RST_VAL}};
        else     res_q <= res_d;
    end
    assign {out_valid, p, g, co, s} = res;
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed checks of combinational, registered and chained adders
module tb_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    logic a0 = 0, b0 = 0, ci0 = 0, iv0 = 0;
    logic [4:0] out0;
    full_adder #(.OUT_REG(0)) u_comb (
        .clk(clk), .rst(rst),
        .s(out0[0]), .co(out0[1]), .g(out0[2]), .p(out0[3]), .out_valid(out0[4]),
        .a(a0), .b(b0), .ci(ci0), .in_valid(iv0)
    );

    logic a1 = 0, b1 = 0, ci1 = 0, iv1 = 0;
    logic [4:0] out1;
    full_adder #(.OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst),
        .s(out1[0]), .co(out1[1]), .g(out1[2]), .p(out1[3]), .out_valid(out1[4]),
        .a(a1), .b(b1), .ci(ci1), .in_valid(iv1)
    );

    logic [3:0] e1 = 0, e2 = 0;
    logic [3:0] chain_s, chain_g, chain_p, chain_v;
    logic [4:0] c;
    logic chain_ci = 0;
    assign c[0] = chain_ci;
    for (genvar k = 0; k < 4; k++) begin : g_chain
        full_adder #(.OUT_REG(0)) u_fa (
            .clk(clk), .rst(rst),
            .s(chain_s[k]), .co(c[k+1]), .g(chain_g[k]), .p(chain_p[k]), .out_valid(chain_v[k]),
            .a(e1[k]), .b(e2[k]), .ci(c[k]), .in_valid(1'b1)
        );
    end

    // reference: arithmetic sum of the operand bits, packed as {valid, p, g, co, s}
    function automatic logic [4:0] model(input logic a, input logic b, input logic ci, input logic iv);
        int ab = a + b;
        int sum = ab + ci;
        return {iv, ab == 1, ab == 2, sum >= 2, sum % 2 == 1};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [4:0] prev;
        logic [8:0] v;
        #2 rst = 1'b1;
        #1 check("reg_reset", 16'(out1), 16'h0);
        // combinational instance ignores reset
        a0 = 1; b0 = 1; ci0 = 0; iv0 = 1;
        #1 check("comb_under_rst", 16'(out0), 16'(model(1, 1, 0, 1)));
        for (int i = 0; i < 8; i++) begin
            {a0, b0, ci0} = 3'(i);
            iv0 = i[0];
            #1 check("comb_exh", 16'(out0), 16'(model(a0, b0, ci0, iv0)));
        end
        for (int i = 0; i < 20; i++) begin
            {a0, b0, ci0, iv0} = 4'($urandom);
            #1 check("comb_rand", 16'(out0), 16'(model(a0, b0, ci0, iv0)));
        end
        @(posedge clk);
        #1 check("reg_held_in_rst", 16'(out1), 16'h0);
        // registered instance: one-cycle latency
        @(negedge clk);
        rst = 1'b0;
        #1 check("reg_after_rel", 16'(out1), 16'h0);
        @(negedge clk);
        {a1, b1, ci1, iv1} = 4'hF;
        #1 check("reg_before_edge", 16'(out1), 16'h0);
        @(posedge clk);
        #1 check("reg_111", 16'(out1), 16'(model(1, 1, 1, 1)));
        // async reset between edges while co=1
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("reg_async_rst", 16'(out1), 16'h0);
        @(posedge clk);
        #1 check("reg_rst_edge", 16'(out1), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reg_rst_fall", 16'(out1), 16'h0);
        @(posedge clk);
        #1 check("reg_first_cap", 16'(out1), 16'(model(1, 1, 1, 1)));
        prev = model(1, 1, 1, 1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            {a1, b1, ci1, iv1} = 4'($urandom);
            #1 check("reg_hold", 16'(out1), 16'(prev));
            @(posedge clk);
            prev = model(a1, b1, ci1, iv1);
            #1 check("reg_rand", 16'(out1), 16'(prev));
        end
        // ripple chain of four
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            {chain_ci, e1, e2} = v;
            #1 check("chain", 16'({c[4], chain_s}), 16'(e1 + e2 + chain_ci));
        end
        e1 = 4'hF; e2 = 4'h0; chain_ci = 0;
        #1 check("carry_ci0", 16'({c[4], chain_s}), 16'h0F);
        chain_ci = 1;
        #1 check("carry_ci1", 16'({c[4], chain_s}), 16'h10);
        e1 = 4'hF; e2 = 4'h1;
        #1 check("chain_max", 16'({c[4], chain_s}), 16'h11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
